// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter for the PicoRV32 native memory interface.
// The winning request is latched onto the downstream port and held there
// until the downstream side pulses mem_ready. Selection is round-robin or
// fixed priority (m0 first). Per-master saturating stall counters record how
// long each master waited without being served.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no transaction outstanding; any valid request is granted
// S_BUSY | latched request presented downstream, waiting for mem_ready

module picorv32_mem_arbiter #(
    parameter int PRIO_MODE   = 0,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   m0_mem_valid,
    input  logic                   m0_mem_instr,
    input  logic [31:0]            m0_mem_addr,
    input  logic [31:0]            m0_mem_wdata,
    input  logic [3:0]             m0_mem_wstrb,
    output logic                   m0_mem_ready,
    output logic [31:0]            m0_mem_rdata,

    input  logic                   m1_mem_valid,
    input  logic                   m1_mem_instr,
    input  logic [31:0]            m1_mem_addr,
    input  logic [31:0]            m1_mem_wdata,
    input  logic [3:0]             m1_mem_wstrb,
    output logic                   m1_mem_ready,
    output logic [31:0]            m1_mem_rdata,

    output logic                   mem_valid,
    output logic                   mem_instr,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wstrb,
    input  logic                   mem_ready,
    input  logic [31:0]            mem_rdata,

    output logic                   grant_owner,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] m0_stall_cnt,
    output logic [STALL_CNT_W-1:0] m1_stall_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic                   r_owner;
    logic                   r_rr_ptr;
    logic                   r_mem_valid;
    logic                   r_mem_instr;
    logic [31:0]            r_mem_addr;
    logic [31:0]            r_mem_wdata;
    logic [3:0]             r_mem_wstrb;
    logic [STALL_CNT_W-1:0] r_m0_stall;
    logic [STALL_CNT_W-1:0] r_m1_stall;

    logic                   w_busy;
    logic                   w_any_req;
    logic                   w_winner;
    logic                   w_m0_served;
    logic                   w_m1_served;

    assign w_busy      = (r_state == S_BUSY);
    assign w_any_req   = m0_mem_valid | m1_mem_valid;
    assign w_m0_served = w_busy & ~r_owner;
    assign w_m1_served = w_busy &  r_owner;

    // Winner selection: a lone requester always wins; on contention the
    // round-robin pointer or the fixed m0 priority breaks the tie.
    always_comb begin
        w_winner = ~m0_mem_valid;
        if (PRIO_MODE == 0 && m0_mem_valid && m1_mem_valid) begin
            w_winner = r_rr_ptr;
        end
    end

    // Grant/complete FSM; downstream request fields are registered and held
    // for the whole transaction regardless of what the masters do upstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_mem_instr <= w_winner ? m1_mem_instr : m0_mem_instr;
                        r_mem_addr  <= w_winner ? m1_mem_addr  : m0_mem_addr;
                        r_mem_wdata <= w_winner ? m1_mem_wdata : m0_mem_wdata;
                        r_mem_wstrb <= w_winner ? m1_mem_wstrb : m0_mem_wstrb;
                        r_mem_valid <= 1'b1;
                        r_owner     <= w_winner;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_rr_ptr    <= ~r_owner;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall counters: count cycles a master asks but is not the one being
    // served; they stick at all-ones until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m0_stall <= '0;
            r_m1_stall <= '0;
        end else begin
            if (m0_mem_valid && !w_m0_served && !(&r_m0_stall)) begin
                r_m0_stall <= r_m0_stall + STALL_ONE;
            end
            if (m1_mem_valid && !w_m1_served && !(&r_m1_stall)) begin
                r_m1_stall <= r_m1_stall + STALL_ONE;
            end
        end
    end

    assign m0_mem_ready = w_m0_served & mem_ready;
    assign m1_mem_ready = w_m1_served & mem_ready;
    assign m0_mem_rdata = mem_rdata;
    assign m1_mem_rdata = mem_rdata;

    assign mem_valid    = r_mem_valid;
    assign mem_instr    = r_mem_instr;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wstrb    = r_mem_wstrb;

    assign grant_owner  = r_owner;
    assign busy         = w_busy;
    assign m0_stall_cnt = r_m0_stall;
    assign m1_stall_cnt = r_m1_stall;

endmodule
